// File: rtl/prog_load_if.sv
// prog_load_if: groups the UART-side input strobe and the assembler/CPU-side
// outputs of the program-load frame controller.
// master: the environment (drives received bytes, observes the controller).
// slave : the frame controller itself.
interface prog_load_if;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic [7:0] byte_out;
   logic       byte_vld;
   logic       asm_clr;
   logic       cpu_rst;
   logic       busy;
   logic       load_done;
   logic [1:0] err_code;
   logic [8:0] words_loaded;

   modport master (
      output rx_data, rx_vld,
      input  byte_out, byte_vld, asm_clr, cpu_rst, busy, load_done,
             err_code, words_loaded
   );

   modport slave (
      input  rx_data, rx_vld,
      output byte_out, byte_vld, asm_clr, cpu_rst, busy, load_done,
             err_code, words_loaded
   );
endinterface

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: parses a framed program download from the UART receiver
// (start byte, word count, payload, optional checksum), forwards payload
// bytes to the byte-to-word assembler, re-aligns the assembler at each new
// frame and holds the processor in reset until a frame completes cleanly.
// Optional feature macro: PROG_LOAD_CHKSUM_EN (adds the checksum byte, the
// CHK state and the XOR accumulator). Undefined, a frame ends after its
// last payload byte.
module prog_load_ctrl #(
   parameter logic [7:0] START_BYTE     = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input logic        clk,
   input logic        rst,
   prog_load_if.slave bus
);

   // Idle-gap timer counts 0..TIMEOUT_CYCLES-1; expiry is detected when it
   // sits at its last value and no byte arrives on that edge.
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PROG_LOAD_CHKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
`endif

   state_t      state_reg;
   logic [7:0]  byte_out_reg;
   logic        byte_vld_reg;
   logic        asm_clr_reg;
   logic        cpu_rst_reg;
   logic        load_done_reg;
   logic [1:0]  err_code_reg;
   logic [8:0]  words_reg;
   logic [9:0]  byte_cnt_reg;
   logic [9:0]  total_reg;
   logic [TW-1:0] timer_reg;
`ifdef PROG_LOAD_CHKSUM_EN
   logic [7:0]  acc_reg;
`endif

   logic is_start;
   logic last_byte;
   logic timer_expired;

   assign is_start      = bus.rx_vld && (bus.rx_data == START_BYTE);
   assign last_byte     = (byte_cnt_reg + 10'd1) == total_reg;
   assign timer_expired = (timer_reg == TIMER_LAST);

   // Frame sequencer: all outputs are registered here; strobes default low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         byte_out_reg  <= 8'd0;
         byte_vld_reg  <= 1'b0;
         asm_clr_reg   <= 1'b0;
         cpu_rst_reg   <= 1'b1;
         load_done_reg <= 1'b0;
         err_code_reg  <= 2'd0;
         words_reg     <= 9'd0;
         byte_cnt_reg  <= 10'd0;
         total_reg     <= 10'd0;
         timer_reg     <= '0;
`ifdef PROG_LOAD_CHKSUM_EN
         acc_reg       <= 8'd0;
`endif
      end else begin
         byte_vld_reg <= 1'b0;
         asm_clr_reg  <= 1'b0;
         case (state_reg)
            // A start byte (re)opens a frame from IDLE or DONE alike.
            S_IDLE, S_DONE: begin
               if (is_start) begin
                  asm_clr_reg   <= 1'b1;
                  cpu_rst_reg   <= 1'b1;
                  load_done_reg <= 1'b0;
                  err_code_reg  <= 2'd0;
                  words_reg     <= 9'd0;
                  byte_cnt_reg  <= 10'd0;
                  timer_reg     <= '0;
`ifdef PROG_LOAD_CHKSUM_EN
                  acc_reg       <= 8'd0;
`endif
                  state_reg     <= S_LEN;
               end
            end
            S_LEN: begin
               if (bus.rx_vld) begin
                  // Word count 0 encodes 256 words, i.e. 512 bytes.
                  total_reg <= (bus.rx_data == 8'd0) ? 10'd512
                                                     : {1'b0, bus.rx_data, 1'b0};
                  timer_reg <= '0;
                  state_reg <= S_DATA;
               end else if (timer_expired) begin
                  err_code_reg <= 2'd2;
                  cpu_rst_reg  <= 1'b1;
                  state_reg    <= S_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_DATA: begin
               if (bus.rx_vld) begin
                  byte_out_reg <= bus.rx_data;
                  byte_vld_reg <= 1'b1;
                  byte_cnt_reg <= byte_cnt_reg + 10'd1;
                  timer_reg    <= '0;
                  // Odd count before increment means this byte completes a word.
                  if (byte_cnt_reg[0])
                     words_reg <= words_reg + 9'd1;
`ifdef PROG_LOAD_CHKSUM_EN
                  acc_reg <= acc_reg ^ bus.rx_data;
                  if (last_byte)
                     state_reg <= S_CHK;
`else
                  if (last_byte) begin
                     load_done_reg <= 1'b1;
                     cpu_rst_reg   <= 1'b0;
                     state_reg     <= S_DONE;
                  end
`endif
               end else if (timer_expired) begin
                  err_code_reg <= 2'd2;
                  cpu_rst_reg  <= 1'b1;
                  state_reg    <= S_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
`ifdef PROG_LOAD_CHKSUM_EN
            S_CHK: begin
               if (bus.rx_vld) begin
                  timer_reg <= '0;
                  if (bus.rx_data == acc_reg) begin
                     load_done_reg <= 1'b1;
                     cpu_rst_reg   <= 1'b0;
                     state_reg     <= S_DONE;
                  end else begin
                     err_code_reg <= 2'd1;
                     cpu_rst_reg  <= 1'b1;
                     state_reg    <= S_IDLE;
                  end
               end else if (timer_expired) begin
                  err_code_reg <= 2'd2;
                  cpu_rst_reg  <= 1'b1;
                  state_reg    <= S_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
`endif
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.byte_out     = byte_out_reg;
   assign bus.byte_vld     = byte_vld_reg;
   assign bus.asm_clr      = asm_clr_reg;
   assign bus.cpu_rst      = cpu_rst_reg;
   assign bus.load_done    = load_done_reg;
   assign bus.err_code     = err_code_reg;
   assign bus.words_loaded = words_reg;
`ifdef PROG_LOAD_CHKSUM_EN
   assign bus.busy = (state_reg == S_LEN) || (state_reg == S_DATA) ||
                     (state_reg == S_CHK);
`else
   assign bus.busy = (state_reg == S_LEN) || (state_reg == S_DATA);
`endif

endmodule
